// File: rtl/tempo_pkg.sv
// Shared types and default constants for the tap-tempo beat recovery block.
package tempo_pkg;

   localparam int unsigned CLK_HZ         = 12_000_000;
   localparam int unsigned CNT_W          = 26;
   localparam int unsigned DEFAULT_PERIOD = 6_000_000;
   localparam int unsigned MIN_PERIOD     = 1_200_000;
   localparam int unsigned MAX_PERIOD     = 24_000_000;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_e;

endpackage

// File: rtl/tap_sync.sv
// Brings the asynchronous tap button into the clk domain and flags its rising edge.
module tap_sync (
   input  logic clk,
   input  logic rst,
   input  logic tap,
   output logic edge_c
);

   logic sync1;
   logic sync2;
   logic sync3;

   // Two-flop synchronizer followed by one history flop for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= tap;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign edge_c = sync2 & ~sync3;

endmodule

// File: rtl/tap_tempo.sv
// Measures the interval between button taps, averages it into a beat period and
// regenerates a one-cycle beat pulse phase-aligned to the latest accepted tap.
module tap_tempo #(
   parameter int unsigned CNT_W          = tempo_pkg::CNT_W,
   parameter int unsigned DEFAULT_PERIOD = tempo_pkg::DEFAULT_PERIOD,
   parameter int unsigned MIN_PERIOD     = tempo_pkg::MIN_PERIOD,
   parameter int unsigned MAX_PERIOD     = tempo_pkg::MAX_PERIOD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tap,
   output logic             beat_pulse,
   output logic [CNT_W-1:0] period,
   output logic             locked
);

   import tempo_pkg::*;

   localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
   localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(MAX_PERIOD - 1);
   localparam logic [CNT_W:0]   MIN_IVL    = (CNT_W+1)'(MIN_PERIOD);

   state_e           state;
   logic [CNT_W-1:0] ivl_cnt;
   logic [CNT_W-1:0] beat_cnt;
   logic             tap_edge;
   logic [CNT_W:0]   interval;
   logic [CNT_W:0]   avg_sum;
   logic             accept;
   logic             beat_wrap;

   tap_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .tap    (tap),
      .edge_c (tap_edge)
   );

   // Interval of the current edge, running average sum and tap acceptance.
   always_comb begin
      interval  = {1'b0, ivl_cnt} + (CNT_W+1)'(1);
      avg_sum   = {1'b0, period} + interval;
      accept    = tap_edge && ((state == IDLE) || (interval >= MIN_IVL));
      beat_wrap = (beat_cnt >= (period - CNT_W'(1)));
   end

   // Tap FSM: measures intervals, updates the averaged period, times out to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ivl_cnt <= '0;
         period  <= RST_PERIOD;
         locked  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (tap_edge) begin
                  state   <= MEASURE;
                  ivl_cnt <= '0;
               end
            end
            MEASURE: begin
               if (accept) begin
                  // An edge coinciding with the timeout is still a valid tap.
                  if (locked) begin
                     period <= CNT_W'(avg_sum >> 1);
                  end else begin
                     period <= CNT_W'(interval);
                  end
                  locked  <= 1'b1;
                  ivl_cnt <= '0;
               end else if (ivl_cnt == TIMEOUT) begin
                  state   <= IDLE;
                  ivl_cnt <= '0;
               end else begin
                  ivl_cnt <= ivl_cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               ivl_cnt <= '0;
            end
         endcase
      end
   end

   // Beat generator: free-running wrap at period, realigned by every accepted tap.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt   <= '0;
         beat_pulse <= 1'b0;
      end else if (accept || beat_wrap) begin
         beat_cnt   <= '0;
         beat_pulse <= 1'b1;
      end else begin
         beat_cnt   <= beat_cnt + CNT_W'(1);
         beat_pulse <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tap_tempo.sv
// Scoreboard bench for tap_tempo: expected beat cycles are queued as taps are
// driven and matched against beat_pulse by a monitor on the falling edge.
module tb_tap_tempo;

   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             tap = 1'b0;
   logic             beat_pulse;
   logic [CNT_W-1:0] period;
   logic             locked;

   int cyc      = 0;
   int n_cmp    = 0;
   int n_err    = 0;
   int nat      = 0;
   int per      = 20;
   int last_tap = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   tap_tempo #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (20),
      .MIN_PERIOD     (8),
      .MAX_PERIOD     (100)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tap        (tap),
      .beat_pulse (beat_pulse),
      .period     (period),
      .locked     (locked)
   );

   // Beat monitor: every pulse must match the head of the expected queue.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
         n_cmp++;
         n_err++;
         $display("FAIL beat_missing: no pulse at cycle %0d (now %0d)", exp_q[0], cyc);
         void'(exp_q.pop_front());
      end
      if (beat_pulse) begin
         n_cmp++;
         if (exp_q.size() > 0 && exp_q[0] == cyc) begin
            void'(exp_q.pop_front());
         end else begin
            n_err++;
            $display("FAIL beat_unexpected: pulse at cycle %0d, next expected %0d",
                     cyc, (exp_q.size() > 0) ? exp_q[0] : -1);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Queue natural beats that fall before cycle t, then advance to t.
   task automatic run_until(input int t);
      while (nat < t) begin
         exp_q.push_back(nat);
         nat += per;
      end
      while (cyc < t) step(1);
   endtask

   // One-cycle tap that must be accepted: pulse 3 cycles later, then new_per.
   task automatic tap_accept(input int new_per);
      int t;
      t = cyc;
      while (nat < t + 3) begin
         exp_q.push_back(nat);
         nat += per;
      end
      exp_q.push_back(t + 3);
      nat      = t + 3 + new_per;
      per      = new_per;
      last_tap = t;
      tap = 1'b1;
      step(1);
      tap = 1'b0;
   endtask

   task automatic tap_ignored();
      tap = 1'b1;
      step(1);
      tap = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(3);
      n_cmp++;
      if (beat_pulse !== 1'b0) begin
         n_err++; $display("FAIL reset_pulse: got %b want 0", beat_pulse);
      end
      n_cmp++;
      if (period !== 8'd20) begin
         n_err++; $display("FAIL reset_period: got %0d want 20", period);
      end
      n_cmp++;
      if (locked !== 1'b0) begin
         n_err++; $display("FAIL reset_locked: got %b want 0", locked);
      end
      rst = 1'b0;
      nat = cyc + 20;
      per = 20;
   endtask

   task automatic test_default();
      run_until(cyc + 65);
      n_cmp++;
      if (period !== 8'd20 || locked !== 1'b0) begin
         n_err++; $display("FAIL default_run: period %0d locked %b want 20/0", period, locked);
      end
   endtask

   task automatic test_lock();
      tap_accept(20);
      step(2);
      n_cmp++;
      if (period !== 8'd20 || locked !== 1'b0) begin
         n_err++; $display("FAIL idle_tap: period %0d locked %b want 20/0", period, locked);
      end
      run_until(last_tap + 40);
      tap_accept(40);
      step(2);
      n_cmp++;
      if (period !== 8'd40 || locked !== 1'b1) begin
         n_err++; $display("FAIL first_lock: period %0d locked %b want 40/1", period, locked);
      end
   endtask

   task automatic test_average();
      run_until(last_tap + 60);
      tap_accept(50);
      step(2);
      n_cmp++;
      if (period !== 8'd50) begin
         n_err++; $display("FAIL average_40_60: got %0d want 50", period);
      end
   endtask

   task automatic test_glitch();
      run_until(last_tap + 3);
      tap_ignored();
      step(5);
      n_cmp++;
      if (period !== 8'd50) begin
         n_err++; $display("FAIL glitch_ignored: got %0d want 50", period);
      end
      run_until(last_tap + 45);
      tap_accept(47);
      step(2);
      n_cmp++;
      if (period !== 8'd47) begin
         n_err++; $display("FAIL after_glitch: got %0d want 47", period);
      end
   endtask

   task automatic test_timeout();
      run_until(last_tap + 150);
      n_cmp++;
      if (period !== 8'd47 || locked !== 1'b1) begin
         n_err++; $display("FAIL timeout_keep: period %0d locked %b want 47/1", period, locked);
      end
      tap_accept(47);
      step(2);
      n_cmp++;
      if (period !== 8'd47) begin
         n_err++; $display("FAIL idle_realign: got %0d want 47", period);
      end
      run_until(last_tap + 30);
      tap_accept(38);
      step(2);
      n_cmp++;
      if (period !== 8'd38) begin
         n_err++; $display("FAIL relock_avg: got %0d want 38", period);
      end
   endtask

   task automatic test_min_interval();
      run_until(last_tap + 7);
      tap_ignored();
      step(5);
      n_cmp++;
      if (period !== 8'd38) begin
         n_err++; $display("FAIL interval_7_ignored: got %0d want 38", period);
      end
      run_until(last_tap + 60);
      tap_accept(49);
      run_until(last_tap + 8);
      tap_accept(28);
      step(2);
      n_cmp++;
      if (period !== 8'd28) begin
         n_err++; $display("FAIL interval_8_accepted: got %0d want 28", period);
      end
   endtask

   task automatic test_reset_flush();
      run_until(last_tap + 40);
      tap = 1'b1;
      step(1);
      tap = 1'b0;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1] >= cyc) void'(exp_q.pop_back());
      nat = cyc + 20;
      per = 20;
      n_cmp++;
      if (period !== 8'd20 || locked !== 1'b0 || beat_pulse !== 1'b0) begin
         n_err++; $display("FAIL mid_reset: period %0d locked %b pulse %b want 20/0/0",
                           period, locked, beat_pulse);
      end
      run_until(cyc + 45);
      tap_accept(20);
      step(2);
      n_cmp++;
      if (period !== 8'd20 || locked !== 1'b0) begin
         n_err++; $display("FAIL post_reset_idle: period %0d locked %b want 20/0", period, locked);
      end
   endtask

   initial begin
      step(1);
      test_reset();
      test_default();
      test_lock();
      test_average();
      test_glitch();
      test_timeout();
      test_min_interval();
      test_reset_flush();
      step(10);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL scoreboard_drain: %0d beats outstanding want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
